// File: rtl/rd_burst_seq_if.sv
// ---------------------------------------------------------------------------
// rd_burst_seq_if: control, read-helper and output-stream signals of rd_burst_seq. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rd_burst_seq_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int BUS_WIDTH     = 32,
  parameter int MAX_BURST_LEN = 4,
  parameter int COUNT_WIDTH   = 16
) ();
  logic                               start;
  logic [ADDR_WIDTH-1:0]              base_addr;
  logic [COUNT_WIDTH-1:0]             word_count;
  logic                               busy;
  logic                               done;
  logic                               error;
  logic                               rd_enable;
  logic [ADDR_WIDTH-1:0]              rd_addr;
  logic [3:0]                         rd_burst_len;
  logic [2:0]                         rd_burst_size;
  logic [MAX_BURST_LEN*BUS_WIDTH-1:0] rd_data;
  logic [1:0]                         rd_status;
  logic [BUS_WIDTH-1:0]               out_data;
  logic                               out_valid;
  logic                               out_ready;

  // master: the sequencer itself; slave: the controller, read helper and stream sink
  modport master (
    input  start, base_addr, word_count, rd_data, rd_status, out_ready,
    output busy, done, error, rd_enable, rd_addr, rd_burst_len, rd_burst_size,
    output out_data, out_valid
  );

  modport slave (
    output start, base_addr, word_count, rd_data, rd_status, out_ready,
    input  busy, done, error, rd_enable, rd_addr, rd_burst_len, rd_burst_size,
    input  out_data, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/rd_burst_seq.sv
// ---------------------------------------------------------------------------
// rd_burst_seq: splits a word-count read into 4 KB-safe bursts and streams the beats. Rev 1.0
// Option: define RD_SEQ_ABORT_ON_ERROR_EN to stop issuing bursts after an error response.
// ---------------------------------------------------------------------------
`default_nettype none

module rd_burst_seq #(
  parameter int ADDR_WIDTH    = 32,
  parameter int BUS_WIDTH     = 32,
  parameter int MAX_BURST_LEN = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input wire             clock,
  input wire             reset_n,
  rd_burst_seq_if.master seq_if
);

  localparam int BYTE_SHIFT = $clog2(BUS_WIDTH / 8);
  localparam int DATA_W     = MAX_BURST_LEN * BUS_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    DRAIN   = 3'd2,
    RELEASE = 3'd3,
    FIN     = 3'd4
  } state_e;

  state_e                 state_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [COUNT_WIDTH-1:0] remaining_q;
  logic [4:0]             beats_q;
  logic [4:0]             left_q;
  logic [DATA_W-1:0]      data_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   error_q;
  logic                   rd_enable_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [3:0]             rd_burst_len_q;
  logic [BUS_WIDTH-1:0]   out_data_q;
  logic                   out_valid_q;

  logic [4:0]             first_beats_d;
  logic [4:0]             next_beats_d;
  logic                   more_d;

  // Beats = min(remaining, MAX_BURST_LEN, beats left before the next 4 KB page)
  function automatic logic [4:0] calc_beats(input logic [11:0] page_off,
                                            input logic [COUNT_WIDTH-1:0] rem);
    logic [12:0] room;
    logic [4:0]  n;
    room = (13'd4096 - {1'b0, page_off}) >> BYTE_SHIFT;
    n    = 5'(MAX_BURST_LEN);
    if (room < 13'(n)) n = room[4:0];
    if (rem < COUNT_WIDTH'(n)) n = rem[4:0];
    return n;
  endfunction

  assign first_beats_d = calc_beats(seq_if.base_addr[11:0], seq_if.word_count);
  assign next_beats_d  = calc_beats(addr_q[11:0], remaining_q);

`ifdef RD_SEQ_ABORT_ON_ERROR_EN
  // error_q is cleared by each accepted start, so it marks an error in this transfer
  assign more_d = (remaining_q != '0) && !error_q;
`else
  assign more_d = (remaining_q != '0);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      remaining_q    <= '0;
      beats_q        <= '0;
      left_q         <= '0;
      data_q         <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      rd_enable_q    <= 1'b0;
      rd_addr_q      <= '0;
      rd_burst_len_q <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (seq_if.start) begin
            error_q     <= 1'b0;
            busy_q      <= 1'b1;
            addr_q      <= seq_if.base_addr;
            remaining_q <= seq_if.word_count;
            if (seq_if.word_count == '0) begin
              state_q <= FIN;
            end else begin
              state_q        <= REQ;
              beats_q        <= first_beats_d;
              rd_enable_q    <= 1'b1;
              rd_addr_q      <= seq_if.base_addr;
              rd_burst_len_q <= 4'(first_beats_d - 5'd1);
            end
          end
        end
        REQ: begin
          if (seq_if.rd_status[1]) begin
            data_q      <= seq_if.rd_data;
            rd_enable_q <= 1'b0;
            left_q      <= beats_q;
            if (seq_if.rd_status == 2'd3) error_q <= 1'b1;
            addr_q      <= addr_q + (ADDR_WIDTH'(beats_q) << BYTE_SHIFT);
            remaining_q <= remaining_q - COUNT_WIDTH'(beats_q);
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          // Beats shift out of the low end of data_q; the first is loaded one cycle after capture
          if (!out_valid_q) begin
            out_data_q  <= data_q[BUS_WIDTH-1:0];
            data_q      <= data_q >> BUS_WIDTH;
            out_valid_q <= 1'b1;
          end else if (seq_if.out_ready) begin
            if (left_q == 5'd1) begin
              out_valid_q <= 1'b0;
              state_q     <= RELEASE;
            end else begin
              out_data_q <= data_q[BUS_WIDTH-1:0];
              data_q     <= data_q >> BUS_WIDTH;
            end
            left_q <= left_q - 5'd1;
          end
        end
        RELEASE: begin
          if (seq_if.rd_status == 2'd0) begin
            if (more_d) begin
              state_q        <= REQ;
              beats_q        <= next_beats_d;
              rd_enable_q    <= 1'b1;
              rd_addr_q      <= addr_q;
              rd_burst_len_q <= 4'(next_beats_d - 5'd1);
            end else begin
              state_q <= FIN;
            end
          end
        end
        FIN: begin
          // done is registered on the way out, so it is seen in the first IDLE cycle
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign seq_if.busy          = busy_q;
  assign seq_if.done          = done_q;
  assign seq_if.error         = error_q;
  assign seq_if.rd_enable     = rd_enable_q;
  assign seq_if.rd_addr       = rd_addr_q;
  assign seq_if.rd_burst_len  = rd_burst_len_q;
  assign seq_if.rd_burst_size = 3'(BYTE_SHIFT);
  assign seq_if.out_data      = out_data_q;
  assign seq_if.out_valid     = out_valid_q;

endmodule

`default_nettype wire

// File: doc/rd_burst_seq.md
RD_BURST_SEQ -- requirements
Module: rd_burst_seq

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte address width.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 32, meaning bits per beat, either 32 or 64.
REQ-003 The block SHALL have parameter MAX_BURST_LEN, default 4, meaning the maximum beats per burst, range 1..16.
REQ-004 The block SHALL have parameter COUNT_WIDTH, default 16, meaning the width of the word-count input.
REQ-005 The block SHALL have port clock, input, 1 bit: the rising-edge clock.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port start, input, 1 bit: request a transfer; sampled only in IDLE.
REQ-008 The block SHALL have port base_addr, input, ADDR_WIDTH bits: first byte address, aligned to BUS_WIDTH/8.
REQ-009 The block SHALL have port word_count, input, COUNT_WIDTH bits: total number of beats to read.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when the transfer completes.
REQ-012 The block SHALL have port error, output, 1 bit: sticky flag for any error response in the current or last transfer.
REQ-013 The block SHALL have port rd_enable, output, 1 bit: enable to the AXI read helper.
REQ-014 The block SHALL have port rd_addr, output, ADDR_WIDTH bits: burst start address.
REQ-015 The block SHALL have port rd_burst_len, output, 4 bits: beats minus 1.
REQ-016 The block SHALL have port rd_burst_size, output, 3 bits: constant log2(BUS_WIDTH/8).
REQ-017 The block SHALL have port rd_data, input, MAX_BURST_LEN*BUS_WIDTH bits: burst data; beat i occupies bits [i*BUS_WIDTH +: BUS_WIDTH].
REQ-018 The block SHALL have port rd_status, input, 2 bits: helper status (0 ready, 1 wait, 2 ok, 3 error).
REQ-019 The block SHALL have port out_data, output, BUS_WIDTH bits: stream word.
REQ-020 The block SHALL have port out_valid, output, 1 bit: stream valid.
REQ-021 The block SHALL have port out_ready, input, 1 bit: stream ready.

Function
REQ-022 The state machine SHALL have states IDLE, REQ, DRAIN, RELEASE and FIN.
- IDLE -> start=1 latches base_addr and word_count; word_count=0 -> FIN; otherwise -> REQ.
- REQ -> rd_enable=1 is held with stable rd_addr/rd_burst_len; rd_status>=2 captures rd_data and rd_status, drops rd_enable and -> DRAIN.
- DRAIN -> beats are emitted 0..beats-1; after the last handshake -> RELEASE.
- RELEASE -> waits for rd_status==0; remaining>0 -> REQ, else -> FIN.
- FIN -> done=1 for one cycle, then -> IDLE.
REQ-023 Beats per burst SHALL be min(remaining, MAX_BURST_LEN, (4096 - addr[11:0])/(BUS_WIDTH/8)), so no burst crosses a 4 KB boundary.
REQ-024 After each burst, addr SHALL advance by beats*BUS_WIDTH/8 and remaining SHALL decrease by beats; both are computed at full width with no wrap.
REQ-025 The out_valid/out_ready stream handshake SHALL follow these rules:
- A beat transfers when out_valid && out_ready.
- At most one beat transfers per cycle.
- out_data and out_valid stay stable while out_valid && !out_ready.
- out_valid is asserted only in DRAIN.
REQ-026 The first beat of a burst SHALL appear on out_data one cycle after the REQ->DRAIN transition.
REQ-027 rd_status==3 SHALL set error; error SHALL clear only on the next accepted start.
REQ-028 start SHALL be ignored in every state except IDLE.
REQ-029 A new burst SHALL never be requested before rd_status==0 is observed.

Reset
REQ-030 While reset_n=0, the block SHALL drive state=IDLE and busy, done, error, rd_enable, out_valid, rd_addr, rd_burst_len and out_data to 0, from any state including mid-burst.
REQ-031 Synchronous logic SHALL resume on the first clock edge after reset_n rises.

Configuration
REQ-032 Macro RD_SEQ_ABORT_ON_ERROR_EN SHALL control the response to rd_status==3.
- Defined: the burst is still drained; RELEASE then goes to FIN regardless of remaining words, and no further rd_enable is issued.
- Undefined: the transfer continues through all bursts, and error is reported at done.

Verification
REQ-033 The bench SHALL cover the following directed scenarios with BUS_WIDTH=32 and MAX_BURST_LEN=4:
- base 0x1000, count 10 -> bursts (addr,len) = (0x1000,3), (0x1010,3), (0x1020,1); 10 words out in order; one done pulse; error=0.
- base 0x1FF8, count 4 -> (0x1FF8,1) then (0x2000,1).
- out_ready=0 for 5 cycles mid-DRAIN -> out_data and out_valid held constant; rd_enable stays 0.
- count 9, rd_status=3 on the first burst -> with macro: 4 words out, done, error=1, one rd_enable only; without macro: 9 words out, three bursts, error=1.
- count 0 -> done two cycles after start; rd_enable never asserted.
- reset_n pulsed low in DRAIN -> all outputs 0 immediately; a subsequent start behaves as a fresh transfer.
